// File: rtl/counter_wrap_monitor.sv
// Watches a free-running enable counter for legal steps and 15->0 wraps.
// Wraps are counted (saturating) and offered to a consumer over valid/ack;
// illegal counter behaviour raises sticky error flags.
module counter_wrap_monitor #(
  parameter int unsigned CNT_WIDTH  = 4,
  parameter int unsigned WRAP_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cnt_reset,
  input  logic [CNT_WIDTH-1:0]  counter_in,
  input  logic                  clear,
  output logic                  wrap_tick,
  output logic [WRAP_WIDTH-1:0] wrap_count,
  output logic                  err_stall,
  output logic                  err_skip,
  output logic                  rpt_valid,
  output logic [WRAP_WIDTH-1:0] rpt_data,
  input  logic                  rpt_ack,
  output logic                  rpt_overrun
);

  typedef enum logic [0:0] {StArm, StTrack} state_e;

  state_e                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt_d;
  logic                  r_en_d;
  logic                  r_rst_d;
  logic                  r_wrap_tick;
  logic [WRAP_WIDTH-1:0] r_wrap_count;
  logic                  r_err_stall;
  logic                  r_err_skip;
  logic                  r_rpt_valid;
  logic [WRAP_WIDTH-1:0] r_rpt_data;
  logic                  r_rpt_overrun;

  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_hold;
  logic                  w_step;
  logic                  w_stall;
  logic                  w_skip;
  logic                  w_wrap;
  logic [WRAP_WIDTH-1:0] w_count_inc;

  // Classify this cycle's counter value against last cycle's value/enable/reset.
  always_comb begin
    w_cnt_inc = r_cnt_d + CNT_WIDTH'(1);
    w_hold    = (counter_in == r_cnt_d);
    w_step    = (counter_in == w_cnt_inc);
    w_stall   = 1'b0;
    w_skip    = 1'b0;
    if (r_rst_d) begin
      w_skip = (counter_in != '0);
    end else if (r_en_d) begin
      w_stall = w_hold;
      w_skip  = !w_hold && !w_step;
    end else begin
      w_skip = !w_hold;
    end
    // A counter reset landing on zero is never a wrap.
    w_wrap      = !r_rst_d && r_en_d && (r_cnt_d == '1) && (counter_in == '0);
    w_count_inc = (r_wrap_count == '1) ? r_wrap_count : r_wrap_count + WRAP_WIDTH'(1);
  end

  // One-cycle history of the counter and its controls; runs through clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt_d <= '0;
      r_en_d  <= 1'b0;
      r_rst_d <= 1'b0;
    end else begin
      r_cnt_d <= counter_in;
      r_en_d  <= enable;
      r_rst_d <= cnt_reset;
    end
  end

  // Arm/track FSM with registered tick, count, sticky errors and report.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= StArm;
      r_wrap_tick   <= 1'b0;
      r_wrap_count  <= '0;
      r_err_stall   <= 1'b0;
      r_err_skip    <= 1'b0;
      r_rpt_valid   <= 1'b0;
      r_rpt_data    <= '0;
      r_rpt_overrun <= 1'b0;
    end else if (clear) begin
      r_state       <= StArm;
      r_wrap_tick   <= 1'b0;
      r_wrap_count  <= '0;
      r_err_stall   <= 1'b0;
      r_err_skip    <= 1'b0;
      r_rpt_valid   <= 1'b0;
      r_rpt_data    <= '0;
      r_rpt_overrun <= 1'b0;
    end else begin
      unique case (r_state)
        // History is not yet valid: skip checks for this one cycle.
        StArm: begin
          r_state     <= StTrack;
          r_wrap_tick <= 1'b0;
          if (r_rpt_valid && rpt_ack) begin
            r_rpt_valid <= 1'b0;
          end
        end
        StTrack: begin
          r_state     <= StTrack;
          r_wrap_tick <= w_wrap;
          if (w_stall) begin
            r_err_stall <= 1'b1;
          end
          if (w_skip) begin
            r_err_skip <= 1'b1;
          end
          if (w_wrap) begin
            r_wrap_count <= w_count_inc;
            // An ack in the wrap cycle frees the slot for the new report.
            if (!r_rpt_valid || rpt_ack) begin
              r_rpt_valid <= 1'b1;
              r_rpt_data  <= w_count_inc;
            end else begin
              r_rpt_overrun <= 1'b1;
            end
          end else if (r_rpt_valid && rpt_ack) begin
            r_rpt_valid <= 1'b0;
          end
        end
        default: r_state <= StArm;
      endcase
    end
  end

  assign wrap_tick   = r_wrap_tick;
  assign wrap_count  = r_wrap_count;
  assign err_stall   = r_err_stall;
  assign err_skip    = r_err_skip;
  assign rpt_valid   = r_rpt_valid;
  assign rpt_data    = r_rpt_data;
  assign rpt_overrun = r_rpt_overrun;

endmodule
